// File: rtl/regfile_sb.sv
// Integer register file with write-through bypass and a pending-write scoreboard.
// Define RF_PARITY_EN to add per-register even parity (par_inject_i / parity_err_o).
module regfile_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rf_rw_en_i,
    input  logic [4:0]       rd_addr_i,
    input  logic [XLEN-1:0]  wb_data_i,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    output logic [XLEN-1:0]  rs1_data_o,
    output logic [XLEN-1:0]  rs2_data_o,
    input  logic             issue_en_i,
    input  logic [4:0]       issue_rd_i,
    input  logic             sb_flush_i,
    output logic             rs1_busy_o,
    output logic             rs2_busy_o,
    output logic [CNT_W-1:0] pend_cnt_o,
    output logic             sb_full_o
`ifdef RF_PARITY_EN
    ,
    input  logic             par_inject_i,
    output logic             parity_err_o
`endif
);

    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic [XLEN-1:0]  r_regs [NREG];
    logic [NREG-1:0]  r_pend;
    logic [CNT_W-1:0] r_cnt;
    logic             r_full;

    logic [NREG-1:0]  w_pend_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_byp1;
    logic             w_byp2;

    // Register storage; x0 is never written so it stays zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
        end else if (rf_rw_en_i && rd_addr_i != 5'd0) begin
            r_regs[rd_addr_i] <= wb_data_i;
        end
    end

    assign w_byp1 = rf_rw_en_i && (rd_addr_i == rs1_addr_i);
    assign w_byp2 = rf_rw_en_i && (rd_addr_i == rs2_addr_i);

    always_comb begin
        rs1_data_o = '0;
        if (rs1_addr_i != 5'd0) rs1_data_o = w_byp1 ? wb_data_i : r_regs[rs1_addr_i];
    end

    always_comb begin
        rs2_data_o = '0;
        if (rs2_addr_i != 5'd0) rs2_data_o = w_byp2 ? wb_data_i : r_regs[rs2_addr_i];
    end

    // Next pending vector: flush, then writeback clear, then issue set (issue wins).
    always_comb begin
        w_pend_nxt = r_pend;
        if (sb_flush_i) w_pend_nxt = '0;
        if (rf_rw_en_i) w_pend_nxt[rd_addr_i] = 1'b0;
        if (issue_en_i && issue_rd_i != 5'd0) w_pend_nxt[issue_rd_i] = 1'b1;
    end

    // Saturating popcount of the next pending vector.
    always_comb begin
        int unsigned pop;
        pop = 0;
        for (int i = 0; i < int'(NREG); i++) pop = pop + 32'(w_pend_nxt[i]);
        if (pop > CNT_MAX) pop = CNT_MAX;
        w_cnt_nxt = CNT_W'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pend <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == CNT_W'(CNT_MAX));
        end
    end

    assign rs1_busy_o = (rs1_addr_i != 5'd0) && r_pend[rs1_addr_i] && !w_byp1;
    assign rs2_busy_o = (rs2_addr_i != 5'd0) && r_pend[rs2_addr_i] && !w_byp2;
    assign pend_cnt_o = r_cnt;
    assign sb_full_o  = r_full;

`ifdef RF_PARITY_EN
    logic [NREG-1:0] r_par;
    logic            w_perr1;
    logic            w_perr2;

    // Stored parity may be deliberately inverted to exercise the checker.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_par <= '0;
        end else if (rf_rw_en_i && rd_addr_i != 5'd0) begin
            r_par[rd_addr_i] <= (^wb_data_i) ^ par_inject_i;
        end
    end

    assign w_perr1 = (rs1_addr_i != 5'd0) && !w_byp1 &&
                     ((^r_regs[rs1_addr_i]) != r_par[rs1_addr_i]);
    assign w_perr2 = (rs2_addr_i != 5'd0) && !w_byp2 &&
                     ((^r_regs[rs2_addr_i]) != r_par[rs2_addr_i]);
    assign parity_err_o = w_perr1 || w_perr2;
`endif

endmodule
